subtractor_381bit: RTL

SUBTRACTOR_381BIT -- requirements
Module: subtractor_381bit

---
 rtl/adder_pkg.sv | 21 ++
 rtl/subtractor_32bit.sv | 21 ++
 rtl/subtractor_381bit.sv | 117 +++++++++++
 3 files changed

// File: rtl/adder_pkg.sv
// Shared constants and FSM encoding for the multi-cycle 381-bit adder/subtractor.
package adder_pkg;

   // Default operand width and per-cycle slice width.
   localparam int W_DEF  = 381;
   localparam int SW_DEF = 32;

   // Slices per operation and width of the (narrower) top slice.
   localparam int NSLICE = (W_DEF + SW_DEF - 1) / SW_DEF;
   localparam int LAST_W = W_DEF - (NSLICE - 1) * SW_DEF;

   // Slice counter width.
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } state_t;

endpackage

// File: rtl/subtractor_32bit.sv
// Combinational one-slice subtractor: D = aug - sub - borrow_in, borrow_out set on underflow.
module subtractor_32bit
   import adder_pkg::*;
#(
   parameter int SW = SW_DEF
) (
   input  logic [SW-1:0] aug,
   input  logic [SW-1:0] sub,
   input  logic          borrow_in,
   output logic [SW-1:0] D,
   output logic          borrow_out
);

   // One extra bit catches the borrow: a negative result wraps with bit SW set.
   logic [SW:0] diff;

   assign diff       = {1'b0, aug} - {1'b0, sub} - {{SW{1'b0}}, borrow_in};
   assign D          = diff[SW-1:0];
   assign borrow_out = diff[SW];

endmodule

// File: rtl/subtractor_381bit.sv
// Multi-cycle W-bit subtractor: one SW-bit slice per cycle, LS slice first.
module subtractor_381bit
   import adder_pkg::*;
#(
   parameter int W  = W_DEF,
   parameter int SW = SW_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] D,
   output logic         borrow,
   output logic         done
);

   localparam int NS = (W + SW - 1) / SW;
   localparam int LW = W - (NS - 1) * SW;

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, b_q;
   logic [W-1:0]     d_q;
   logic [CNT_W-1:0] cnt_q;
   logic             bflop_q;
   logic             borrow_q;
   logic             done_q;

   logic [SW-1:0]    slice_d;
   logic             slice_bo;
   logic             slice_bo_eff;
   logic             last_slice;
   logic [W-1:0]     d_shift;

   assign last_slice = (cnt_q == CNT_W'(NS - 1));

   // Low slice of the shifting operand registers; upper bits of the top slice arrive zero-padded.
   subtractor_32bit #(.SW(SW)) u_slice (
      .aug        (a_q[SW-1:0]),
      .sub        (b_q[SW-1:0]),
      .borrow_in  (bflop_q),
      .D          (slice_d),
      .borrow_out (slice_bo)
   );

   generate
      if (LW < SW) begin : g_pad
         // With zero padding, the borrow out of bit W-1 shows up as bit LW of the padded
         // result; the top slice also shifts in only LW bits so every slice lands exactly.
         assign slice_bo_eff = last_slice ? slice_d[LW] : slice_bo;
         assign d_shift      = last_slice ? {slice_d[LW-1:0], d_q[W-1:LW]}
                                          : {slice_d, d_q[W-1:SW]};
      end else begin : g_full
         assign slice_bo_eff = slice_bo;
         assign d_shift      = {slice_d, d_q[W-1:SW]};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic: IDLE -> RUN on start, RUN -> FIN after last slice, FIN -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)      state_d = ST_RUN;
         ST_RUN:  if (last_slice) state_d = ST_FIN;
         ST_FIN:                  state_d = ST_IDLE;
         default:                 state_d = ST_IDLE;
      endcase
   end

   // Datapath: capture operands, ripple one slice per RUN cycle, publish result at the end.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_q      <= '0;
         b_q      <= '0;
         d_q      <= '0;
         cnt_q    <= '0;
         bflop_q  <= 1'b0;
         borrow_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  bflop_q <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            ST_RUN: begin
               a_q     <= a_q >> SW;
               b_q     <= b_q >> SW;
               d_q     <= d_shift;
               bflop_q <= slice_bo_eff;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (last_slice) begin
                  borrow_q <= slice_bo_eff;
                  done_q   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign D      = d_q;
   assign borrow = borrow_q;
   assign done   = done_q;

endmodule
